// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath.
// The datapath side (master) supplies decode fields and memory ready; the controller (slave) drives strobes.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               adr_src;
  logic               mem_req;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_src;
  logic [2:0]         alu_control;
  logic               reg_write;
  logic               instr_retired;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, reg_write,
           instr_retired, illegal, dbg_state
  );

  modport slave (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, reg_write,
           instr_retired, illegal, dbg_state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset control FSM: sequences fetch, decode, execute, memory and writeback
// over a shared memory port with a ready handshake; unknown opcodes halt or fall through to FETCH.
module multicycle_controller #(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.slave bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Encoding is visible on dbg_state, so the values are pinned explicitly.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_ready;

  // Ready is masked during reset so FETCH cannot load the IR or PC while rst is low.
  assign w_ready       = bus.mem_ready & rst;
  assign bus.dbg_state = STATE_W'(r_state);

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  funct_alu = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    w_next            = r_state;
    bus.pc_write      = 1'b0;
    bus.adr_src       = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.result_src    = 2'b00;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.imm_src       = 2'b00;
    bus.alu_control   = ALU_ADD;
    bus.reg_write     = 1'b0;
    bus.instr_retired = 1'b0;
    bus.illegal       = 1'b0;

    case (r_state)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = w_ready;
        bus.pc_write   = w_ready;
        if (w_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b10;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = (bus.op == OP_SW) ? 2'b01 : 2'b00;
        w_next        = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src    = 2'b01;
        bus.reg_write     = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.mem_req       = 1'b1;
        bus.adr_src       = 1'b1;
        bus.mem_write     = 1'b1;
        bus.instr_retired = w_ready;
        if (w_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = funct_alu(bus.funct3, bus.funct7b5);
        w_next          = S_ALUWB;
      end
      S_EXECI: begin
        // addi has no subtract form, so funct7b5 is ignored for immediates.
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = funct_alu(bus.funct3, 1'b0);
        w_next          = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write     = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        w_next        = S_ALUWB;
      end
      S_BEQ: begin
        bus.alu_src_a     = 2'b10;
        bus.alu_control   = ALU_SUB;
        bus.pc_write      = bus.zero & (bus.funct3 == 3'b000);
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_ILLEGAL: begin
        bus.illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table vectors, random instructions against a
// cycle/strobe-count reference model, and hand-written reset and illegal-opcode sequences.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010;
  localparam logic [2:0] A_OR  = 3'b011;
  localparam logic [2:0] A_SLT = 3'b101;

  localparam int BUDGET = 40;
  localparam int N_TBL  = 17;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         fw;
    int         mw;
    int         cycles;
    int         regw;
    int         memw;
    int         pcw;
    logic [2:0] alu;
    logic [1:0] imm;
  } vec_t;

  typedef struct {
    int         cycles;
    int         regw;
    int         memw;
    int         pcw;
    int         irw;
    int         wait_viol;
    int         strobe_viol;
    logic [2:0] alu;
    logic [1:0] imm;
    logic [1:0] imm_dec;
    logic       timeout;
    logic [3:0] end_state;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4)) if_h ();
  multicycle_controller_if #(.STATE_W(4)) if_n ();

  multicycle_controller #(.STATE_W(4), .ILLEGAL_HALT(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_h)
  );

  multicycle_controller #(.STATE_W(4), .ILLEGAL_HALT(1'b0)) u_dut_nh (
    .clk (clk),
    .rst (rst),
    .bus (if_n)
  );

  assign if_n.op        = if_h.op;
  assign if_n.funct3    = if_h.funct3;
  assign if_n.funct7b5  = if_h.funct7b5;
  assign if_n.zero      = if_h.zero;
  assign if_n.mem_ready = if_h.mem_ready;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] tr_q[$];
  logic [3:0] exp_q[$];
  logic [6:0] ops[6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
  vec_t       tbl[N_TBL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic rdy);
    if_h.mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference: what an instruction must do, derived from the instruction class and wait counts.
  function automatic logic [2:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? A_SUB : A_ADD;
      3'b010:  return A_SLT;
      3'b110:  return A_OR;
      3'b111:  return A_AND;
      default: return A_ADD;
    endcase
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t e;
    e      = v;
    e.regw = 0;
    e.memw = 0;
    e.pcw  = 1;
    e.alu  = A_ADD;
    e.imm  = 2'b00;
    case (v.op)
      OP_LW: begin e.cycles = (v.fw + 1) + 2 + (v.mw + 1) + 1; e.regw = 1; end
      OP_SW: begin e.cycles = (v.fw + 1) + 2 + (v.mw + 1); e.memw = v.mw + 1; e.imm = 2'b01; end
      OP_R:  begin e.cycles = v.fw + 4; e.regw = 1; e.alu = alu_ref(1'b1, v.f3, v.f7); end
      OP_I:  begin e.cycles = v.fw + 4; e.regw = 1; e.alu = alu_ref(1'b0, v.f3, v.f7); end
      OP_JAL: begin e.cycles = v.fw + 4; e.regw = 1; e.pcw = 2; end
      default: begin
        e.cycles = v.fw + 3;
        e.alu    = A_SUB;
        e.pcw    = (v.zero && v.f3 == 3'b000) ? 2 : 1;
      end
    endcase
    return e;
  endfunction

  task automatic build_path(input vec_t v);
    exp_q.delete();
    repeat (v.fw + 1) exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    case (v.op)
      OP_LW: begin
        exp_q.push_back(S_MEMADR);
        repeat (v.mw + 1) exp_q.push_back(S_MEMREAD);
        exp_q.push_back(S_MEMWB);
      end
      OP_SW: begin
        exp_q.push_back(S_MEMADR);
        repeat (v.mw + 1) exp_q.push_back(S_MEMWRITE);
      end
      OP_R:    begin exp_q.push_back(S_EXECR); exp_q.push_back(S_ALUWB); end
      OP_I:    begin exp_q.push_back(S_EXECI); exp_q.push_back(S_ALUWB); end
      OP_JAL:  begin exp_q.push_back(S_JAL);   exp_q.push_back(S_ALUWB); end
      default: exp_q.push_back(S_BEQ);
    endcase
  endtask

  // Drives one instruction from FETCH to retirement; the memory answers after fw/mw wait cycles.
  task automatic run_instr(input vec_t v, output res_t r);
    int left;
    int k;
    bit done;
    left = -1;
    k    = 0;
    done = 1'b0;
    r    = '{default: '0};
    tr_q.delete();
    if_h.op       = v.op;
    if_h.funct3   = v.f3;
    if_h.funct7b5 = v.f7;
    if_h.zero     = v.zero;
    while (!done && k < BUDGET) begin
      if (if_h.mem_req) begin
        if (left < 0) left = if_h.adr_src ? v.mw : v.fw;
        if_h.mem_ready = (left == 0);
        left = (left == 0) ? -1 : left - 1;
      end else begin
        if_h.mem_ready = 1'($urandom_range(1, 0));
        left = -1;
      end
      @(negedge clk);
      tr_q.push_back(if_h.dbg_state);
      if (if_h.reg_write) r.regw++;
      if (if_h.mem_write) r.memw++;
      if (if_h.pc_write)  r.pcw++;
      if (if_h.ir_write)  r.irw++;
      if (if_h.mem_req && !if_h.mem_ready &&
          (if_h.pc_write || if_h.ir_write || if_h.reg_write || if_h.instr_retired))
        r.wait_viol++;
      if ((if_h.mem_write && !(if_h.mem_req && if_h.adr_src)) ||
          (if_h.reg_write && !if_h.instr_retired) || if_h.illegal)
        r.strobe_viol++;
      if (k == v.fw + 1) r.imm_dec = if_h.imm_src;
      if (k == v.fw + 2) begin
        r.alu = if_h.alu_control;
        r.imm = if_h.imm_src;
      end
      if (if_h.instr_retired) done = 1'b1;
      k++;
      @(posedge clk);
      #1;
    end
    r.cycles    = k;
    r.timeout   = !done;
    r.end_state = if_h.dbg_state;
  endtask

  task automatic check_result(input vec_t e, input res_t r);
    check({e.name, "_timeout"},   32'(r.timeout),     32'd0);
    check({e.name, "_cycles"},    32'(r.cycles),      32'(e.cycles));
    check({e.name, "_reg_write"}, 32'(r.regw),        32'(e.regw));
    check({e.name, "_mem_write"}, 32'(r.memw),        32'(e.memw));
    check({e.name, "_pc_write"},  32'(r.pcw),         32'(e.pcw));
    check({e.name, "_ir_write"},  32'(r.irw),         32'd1);
    check({e.name, "_alu"},       32'(r.alu),         32'(e.alu));
    check({e.name, "_imm"},       32'(r.imm),         32'(e.imm));
    check({e.name, "_imm_dec"},   32'(r.imm_dec),     32'd2);
    check({e.name, "_wait"},      32'(r.wait_viol),   32'd0);
    check({e.name, "_strobes"},   32'(r.strobe_viol), 32'd0);
    check({e.name, "_end"},       32'(r.end_state),   32'(S_FETCH));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    if_h.mem_ready = 1'b1;
    #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",    32'(if_h.dbg_state),     32'(S_FETCH));
    check("rst_pc_write", 32'(if_h.pc_write),      32'd0);
    check("rst_ir_write", 32'(if_h.ir_write),      32'd0);
    check("rst_illegal",  32'(if_h.illegal),       32'd0);
    check("rst_retired",  32'(if_h.instr_retired), 32'd0);
    check("rst_mem_req",  32'(if_h.mem_req),       32'd1);
    rst = 1'b1;
    #1;
    check("rel_ir_write",  32'(if_h.ir_write),  32'd1);
    check("rel_pc_write",  32'(if_h.pc_write),  32'd1);
    check("rel_reg_write", 32'(if_h.reg_write), 32'd0);
    check("rel_mem_write", 32'(if_h.mem_write), 32'd0);
    if_h.mem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t e;
    res_t r;
    int   mism;
    int   frozen;
    int   nh_ill;

    tbl[0]  = '{"lw_wait",  OP_LW,  3'b010, 1'b0, 1'b0, 2, 2, 9, 1, 0, 1, A_ADD, 2'b00};
    tbl[1]  = '{"lw",       OP_LW,  3'b010, 1'b0, 1'b0, 0, 0, 5, 1, 0, 1, A_ADD, 2'b00};
    tbl[2]  = '{"sw",       OP_SW,  3'b010, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1, A_ADD, 2'b01};
    tbl[3]  = '{"sw_wait",  OP_SW,  3'b010, 1'b0, 1'b0, 1, 3, 8, 0, 4, 1, A_ADD, 2'b01};
    tbl[4]  = '{"sub",      OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, A_SUB, 2'b00};
    tbl[5]  = '{"add",      OP_R,   3'b000, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, A_ADD, 2'b00};
    tbl[6]  = '{"addi_f7",  OP_I,   3'b000, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, A_ADD, 2'b00};
    tbl[7]  = '{"slt",      OP_R,   3'b010, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, A_SLT, 2'b00};
    tbl[8]  = '{"ori",      OP_I,   3'b110, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, A_OR,  2'b00};
    tbl[9]  = '{"and",      OP_R,   3'b111, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, A_AND, 2'b00};
    tbl[10] = '{"sll_dflt", OP_R,   3'b001, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, A_ADD, 2'b00};
    tbl[11] = '{"slti_w",   OP_I,   3'b010, 1'b0, 1'b0, 2, 0, 6, 1, 0, 1, A_SLT, 2'b00};
    tbl[12] = '{"jal",      OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 4, 1, 0, 2, A_ADD, 2'b00};
    tbl[13] = '{"jal_wait", OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0, 5, 1, 0, 2, A_ADD, 2'b00};
    tbl[14] = '{"beq_t",    OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 3, 0, 0, 2, A_SUB, 2'b00};
    tbl[15] = '{"beq_nt",   OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, A_SUB, 2'b00};
    tbl[16] = '{"bne_z",    OP_BEQ, 3'b001, 1'b0, 1'b1, 0, 0, 3, 0, 0, 1, A_SUB, 2'b00};

    if_h.op        = 7'd0;
    if_h.funct3    = 3'd0;
    if_h.funct7b5  = 1'b0;
    if_h.zero      = 1'b0;
    if_h.mem_ready = 1'b0;

    do_reset();

    for (int i = 0; i < N_TBL; i++) begin
      run_instr(tbl[i], r);
      check_result(tbl[i], r);
    end

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.name   = $sformatf("rnd%0d", i);
      v.op     = ops[$urandom_range(5, 0)];
      v.f3     = 3'($urandom);
      v.f7     = 1'($urandom);
      v.zero   = 1'($urandom);
      v.fw     = $urandom_range(3, 0);
      v.mw     = $urandom_range(3, 0);
      v.cycles = 0;
      v.regw   = 0;
      v.memw   = 0;
      v.pcw    = 0;
      v.alu    = 3'd0;
      v.imm    = 2'd0;
      e = model(v);
      build_path(v);
      run_instr(v, r);
      check_result(e, r);
      mism = (tr_q.size() != exp_q.size()) ? 1 : 0;
      if (mism == 0)
        foreach (exp_q[j]) if (tr_q[j] !== exp_q[j]) mism++;
      check({v.name, "_trace"}, 32'(mism), 32'd0);
    end

    // Reset while a load waits in MEMREAD aborts it without a register write.
    if_h.op = OP_LW;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("mid_lw_state", 32'(if_h.dbg_state), 32'(S_MEMREAD));
    if_h.mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_lw_rst_state", 32'(if_h.dbg_state),     32'(S_FETCH));
    check("mid_lw_rst_regw",  32'(if_h.reg_write),     32'd0);
    check("mid_lw_rst_ret",   32'(if_h.instr_retired), 32'd0);
    check("mid_lw_rst_pcw",   32'(if_h.pc_write),      32'd0);
    do_reset();

    // Reset during a held store write strobe drops it immediately.
    if_h.op = OP_SW;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("mid_sw_state", 32'(if_h.dbg_state), 32'(S_MEMWRITE));
    check("mid_sw_memw",  32'(if_h.mem_write), 32'd1);
    if_h.mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_sw_rst_memw",  32'(if_h.mem_write),     32'd0);
    check("mid_sw_rst_ret",   32'(if_h.instr_retired), 32'd0);
    check("mid_sw_rst_state", 32'(if_h.dbg_state),     32'(S_FETCH));
    do_reset();

    // Illegal opcode: halting instance parks, the other falls back to FETCH.
    if_h.op        = 7'b1111111;
    if_h.funct3    = 3'b000;
    if_h.mem_ready = 1'b1;
    @(negedge clk);
    check("ill_fetch_irw", 32'(if_h.ir_write), 32'd1);
    @(posedge clk);
    #1;
    if_h.mem_ready = 1'b0;
    check("ill_decode_h", 32'(if_h.dbg_state), 32'(S_DECODE));
    check("ill_decode_n", 32'(if_n.dbg_state), 32'(S_DECODE));
    @(posedge clk);
    #1;
    check("ill_state_h", 32'(if_h.dbg_state), 32'(S_ILLEGAL));
    check("ill_flag_h",  32'(if_h.illegal),   32'd1);
    check("ill_state_n", 32'(if_n.dbg_state), 32'(S_FETCH));
    check("ill_flag_n",  32'(if_n.illegal),   32'd0);
    frozen = 0;
    nh_ill = 0;
    repeat (20) begin
      if_h.mem_ready = 1'($urandom);
      @(negedge clk);
      if (if_h.dbg_state !== S_ILLEGAL || if_h.illegal !== 1'b1 ||
          (if_h.mem_req | if_h.pc_write | if_h.ir_write | if_h.reg_write |
           if_h.mem_write | if_h.instr_retired) !== 1'b0)
        frozen++;
      if (if_n.illegal !== 1'b0) nh_ill++;
      @(posedge clk);
      #1;
    end
    check("ill_frozen_h", 32'(frozen), 32'd0);
    check("ill_never_n",  32'(nh_ill), 32'd0);
    rst = 1'b0;
    #1;
    check("ill_clear_flag",  32'(if_h.illegal),   32'd0);
    check("ill_clear_state", 32'(if_h.dbg_state), 32'(S_FETCH));
    do_reset();

    run_instr(tbl[1], r);
    check_result(tbl[1], r);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM that sequences the RV32I-subset datapath: PC, unified instruction/data memory, register file, sign extender and ALU.
- Shares one memory port between instruction fetch and load/store, and waits on a memory ready handshake.
- Generates all datapath select and enable strobes per state, plus ALU decode, retire pulse and an illegal-opcode halt.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- STATE_W, 4, width of the state register and of the dbg_state port.
- ILLEGAL_HALT, 1, 1 = park in ILLEGAL on an unknown opcode; 0 = treat it as a NOP and return to FETCH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- op  input  7  instruction[6:0] from the latched instruction register
- funct3  input  3  instruction[14:12]
- funct7b5  input  1  instruction[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- pc_write  output  1  PC load enable
- adr_src  output  1  memory address select: 0 = PC, 1 = result bus
- mem_req  output  1  memory access request
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register and old_pc load enable
- result_src  output  2  00 = alu_out register, 01 = data register, 10 = ALU result
- alu_src_a  output  2  00 = PC, 01 = old_pc, 10 = rd1
- alu_src_b  output  2  00 = rd2, 01 = imm_ext, 10 = constant 4
- imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  output  1  register file write enable
- instr_retired  output  1  one-cycle pulse on instruction completion
- illegal  output  1  sticky illegal-opcode flag
- dbg_state  output  STATE_W  current state

Behaviour:
- Reset: rst low immediately forces state FETCH, illegal = 0 and instr_retired = 0. All strobes take their FETCH-state values while rst is low, with mem_ready gating forced to 0.
- Reset mid-operation aborts the instruction; no reg_write or mem_write may occur on the edge at which rst deasserts.
- Strobes are Moore-decoded from the state register, except where qualified by mem_ready, zero or funct. Unlisted strobes are 0 and unlisted selects are 00.
- FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu add, result_src = 10. ir_write and pc_write equal mem_ready. Go to DECODE when mem_ready, else stay.
- DECODE: alu_src_a = 01, alu_src_b = 01, imm_src = 10 (precompute the branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> ILLEGAL if ILLEGAL_HALT = 1, else FETCH
- MEMADR: alu_src_a = 10, alu_src_b = 01, add. imm_src = 00 for lw, 01 for sw. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src = 01, reg_write = 1, instr_retired = 1. Go to FETCH.
- MEMWRITE: mem_req = 1, adr_src = 1, result_src = 00. mem_write = 1 is held throughout the state. On mem_ready: instr_retired = 1, go to FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, funct decode. Go to ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, imm_src = 00, funct decode. Go to ALUWB.
- ALUWB: result_src = 00, reg_write = 1, instr_retired = 1. Go to FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, result_src = 00, pc_write = 1. Go to ALUWB, which writes PC+4 to rd.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu sub, result_src = 00. pc_write = zero (beq only; funct3 != 000 never branches). instr_retired = 1. Go to FETCH.
- ILLEGAL: all strobes 0, illegal = 1. Remains there until reset.
- Funct decode (EXECR/EXECI), by funct3:
  - 000: sub if EXECR and funct7b5 = 1, else add. EXECI is always add, since addi ignores funct7b5.
  - 010: slt
  - 110: or
  - 111: and
  - any other funct3: add
- Cycle counts with mem_ready tied high:
  - lw = 5 cycles
  - sw = 4
  - R/I-type = 4
  - jal = 4
  - beq = 3
- Each mem_ready low cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No strobe other than mem_req, adr_src and the held mem_write is asserted while waiting.
- mem_ready asserted outside FETCH, MEMREAD or MEMWRITE is ignored.

Test Plan:
- Reset: hold rst low 3 cycles with mem_ready = 1 -> dbg_state = FETCH, pc_write = 0, ir_write = 0, illegal = 0. First rising edge after release -> ir_write = 1, pc_write = 1.
- Load with wait states: op = 0000011, mem_ready low for 2 cycles in both FETCH and MEMREAD -> state sequence FETCH×3, DECODE, MEMADR, MEMREAD×3, MEMWB. reg_write and instr_retired high only in MEMWB (9 cycles total).
- R-type sub: op = 0110011, funct3 = 000, funct7b5 = 1 -> alu_control = 001 in EXECR. ALUWB has reg_write = 1. Repeat with op = 0010011, funct7b5 = 1 -> alu_control = 000.
- beq: zero = 1 -> pc_write = 1 in BEQ, 3 cycles total. zero = 0 -> pc_write = 0. funct3 = 001 with zero = 1 -> pc_write = 0.
- Store: op = 0100011 -> imm_src = 01 in MEMADR. mem_write = 1 held through MEMWRITE until mem_ready. reg_write never asserted.
- Illegal op 1111111: ILLEGAL_HALT = 1 -> illegal = 1, state frozen for 20 cycles, cleared by rst. ILLEGAL_HALT = 0 -> DECODE then FETCH, illegal = 0.
